link_game_ctrl: RTL and testbench
=================================

Name: link_game_ctrl

Overview:
Top-level gameplay sequencer for the player character. It produces the one-hot phase strobes that drive the character datapath (init, idle, reg_action, apply_action, draw_char) and the map redraw engine. It latches and encodes the key inputs into the 3-bit action code, gates moves against the collision result, and paces movement to the VGA frame tick. It sits directly upstream of the character datapath and the map drawer and consumes their done pulses.

Parameters:
FRAMES_PER_MOVE, 2, frame ticks that must elapse in S_IDLE before an action is sampled (1..15).
CHECK_CYCLES, 2, cycles spent in S_CHECK so the collision lookup can settle before collision is sampled (1..7).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
key_attack  in  1  attack button, active-high, already synchronised
key_up  in  1  up button
key_down  in  1  down button
key_left  in  1  left button
key_right  in  1  right button
frame_tick  in  1  one-cycle pulse per VGA frame
map_done  in  1  map drawer finished pulse
char_done  in  1  character draw finished (draw_done of the character datapath)
collision  in  2  collision result for the latched move; 00 = free, any other value = blocked
init  out  1  character initialise strobe
idle  out  1  waiting-for-frame phase
reg_action  out  1  action latch phase
apply_action  out  1  apply move phase
draw_map  out  1  map redraw enable
draw_char  out  1  character draw enable
user_input  out  3  registered action code: 000 none, 001 attack, 010 up, 011 down, 100 left, 101 right

Behaviour:
- States: S_INIT, S_DRAW_MAP, S_DRAW_CHAR, S_IDLE, S_REG, S_CHECK, S_APPLY. Encoding is free.
- Outputs are Moore and registered. Exactly one of init/draw_map/draw_char/idle/reg_action/apply_action is high per state; S_CHECK drives all of them low.
- Reset: state goes to S_INIT; user_input=000; tick counter=0; pending_tick=0; check counter=0; all strobes 0 in the reset cycle.
- S_INIT: init=1 for exactly 1 cycle, then S_DRAW_MAP.
- S_DRAW_MAP: draw_map=1 until map_done is sampled high, then S_DRAW_CHAR.
- S_DRAW_CHAR: draw_char=1 until char_done is sampled high, then S_IDLE. char_done is ignored on the first cycle of the state (stale pulse guard).
- S_IDLE: idle=1. Each frame_tick, or the pending_tick flag, increments the tick counter. When counter+1 == FRAMES_PER_MOVE on a tick: counter clears and the next state is S_REG.
- pending_tick: set by a frame_tick arriving outside S_IDLE. It is consumed (cleared) on the first S_IDLE cycle. Multiple ticks outside S_IDLE collapse into one.
- S_REG: reg_action=1 for 1 cycle. user_input is loaded from the keys with priority attack > up > down > left > right; no key loads 000. Next state is S_CHECK.
- S_CHECK: lasts exactly CHECK_CYCLES cycles.
  - On the last cycle, if collision != 00 and user_input is in 010..101, user_input is forced to 000.
  - Attack (001) is never blocked.
  - Next state is S_APPLY.
- S_APPLY: apply_action=1 for 1 cycle with the final user_input stable, then S_DRAW_MAP.
- user_input holds its value from S_REG until the next S_REG and is not cleared on S_APPLY exit.
- Key changes outside S_REG have no effect.
- map_done/char_done seen in any other state are ignored.
- Reset mid-operation returns to S_INIT on the next cycle, regardless of state.
- Minimum loop with FRAMES_PER_MOVE=1, CHECK_CYCLES=1, and done pulses arriving immediately: REG 1 + CHECK 1 + APPLY 1 + MAP ≥1 + CHAR ≥2 + IDLE ≥1 cycles.

Test Plan:
- Reset, map_done after 3 cycles, char_done after 256 -> init high 1 cycle, draw_map high exactly 3 cycles, then draw_char, then idle=1, user_input=000.
- FRAMES_PER_MOVE=2 in S_IDLE: one frame_tick -> stays idle; second tick -> reg_action pulses 1 cycle on the next cycle.
- key_up=1 and key_right=1 held through S_REG, collision=00 -> user_input=010 and apply_action pulses once after CHECK_CYCLES cycles.
- key_left=1, collision=01 on the last S_CHECK cycle -> user_input=000 during apply_action; key_attack with collision=11 -> user_input stays 001.
- frame_tick pulsed during S_DRAW_MAP with FRAMES_PER_MOVE=1 -> S_REG is entered on the cycle after S_IDLE is entered, without a new tick.
- reset asserted in S_CHECK -> next cycle all strobes 0 and user_input=000; following cycle init=1.

Source files
------------

// File: rtl/link_game_ctrl_if.sv
// Handshake bundle between the gameplay sequencer and the character/map datapaths.
// The master side is the sequencer; the slave side is the datapath and input logic.
interface link_game_ctrl_if;
  logic       key_attack;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       frame_tick;
  logic       map_done;
  logic       char_done;
  logic [1:0] collision;
  logic       init;
  logic       idle;
  logic       reg_action;
  logic       apply_action;
  logic       draw_map;
  logic       draw_char;
  logic [2:0] user_input;

  modport master (
    input  key_attack, key_up, key_down, key_left, key_right,
    input  frame_tick, map_done, char_done, collision,
    output init, idle, reg_action, apply_action, draw_map, draw_char, user_input
  );

  modport slave (
    output key_attack, key_up, key_down, key_left, key_right,
    output frame_tick, map_done, char_done, collision,
    input  init, idle, reg_action, apply_action, draw_map, draw_char, user_input
  );
endinterface

// File: rtl/link_game_ctrl.sv
// Gameplay sequencer for the player character: phase strobes, key encoding,
// collision gating and frame-paced movement.
module link_game_ctrl #(
  parameter int unsigned FRAMES_PER_MOVE = 2,
  parameter int unsigned CHECK_CYCLES    = 2
) (
  input logic              clock,
  input logic              reset,
  link_game_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StInit,
    StDrawMap,
    StDrawChar,
    StIdle,
    StReg,
    StCheck,
    StApply
  } state_e;

  localparam logic [3:0] FpmLast   = 4'(FRAMES_PER_MOVE - 1);
  localparam logic [2:0] CheckLast = 3'(CHECK_CYCLES - 1);

  localparam logic [2:0] ActNone   = 3'd0;
  localparam logic [2:0] ActAttack = 3'd1;
  localparam logic [2:0] ActUp     = 3'd2;
  localparam logic [2:0] ActDown   = 3'd3;
  localparam logic [2:0] ActLeft   = 3'd4;
  localparam logic [2:0] ActRight  = 3'd5;

  state_e     state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] check_cnt_q, check_cnt_d;
  logic [2:0] user_input_q, user_input_d;
  logic       pending_q, pending_d;
  logic       char_armed_q;
  logic       init_q, idle_q, reg_action_q, apply_action_q, draw_map_q, draw_char_q;
  logic       tick;

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    check_cnt_d  = check_cnt_q;
    user_input_d = user_input_q;
    pending_d    = pending_q;
    tick         = bus.frame_tick | pending_q;

    // Ticks that land while busy are remembered (collapsed to one) for the next idle phase.
    if (state_q != StIdle && bus.frame_tick) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      StInit: begin
        // The reset cycle leaves init low; the following cycle raises it once.
        if (init_q) state_d = StDrawMap;
      end
      StDrawMap: begin
        if (bus.map_done) state_d = StDrawChar;
      end
      StDrawChar: begin
        if (char_armed_q && bus.char_done) state_d = StIdle;
      end
      StIdle: begin
        pending_d = 1'b0;
        if (tick) begin
          if (tick_cnt_q == FpmLast) begin
            tick_cnt_d = '0;
            state_d    = StReg;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      StReg: begin
        if (bus.key_attack)     user_input_d = ActAttack;
        else if (bus.key_up)    user_input_d = ActUp;
        else if (bus.key_down)  user_input_d = ActDown;
        else if (bus.key_left)  user_input_d = ActLeft;
        else if (bus.key_right) user_input_d = ActRight;
        else                    user_input_d = ActNone;
        check_cnt_d = '0;
        state_d     = StCheck;
      end
      StCheck: begin
        if (check_cnt_q == CheckLast) begin
          check_cnt_d = '0;
          if (bus.collision != 2'b00 && user_input_q >= ActUp && user_input_q <= ActRight) begin
            user_input_d = ActNone;
          end
          state_d = StApply;
        end else begin
          check_cnt_d = check_cnt_q + 3'd1;
        end
      end
      StApply: begin
        state_d = StDrawMap;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StInit;
      tick_cnt_q     <= '0;
      check_cnt_q    <= '0;
      user_input_q   <= ActNone;
      pending_q      <= 1'b0;
      char_armed_q   <= 1'b0;
      init_q         <= 1'b0;
      idle_q         <= 1'b0;
      reg_action_q   <= 1'b0;
      apply_action_q <= 1'b0;
      draw_map_q     <= 1'b0;
      draw_char_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      check_cnt_q    <= check_cnt_d;
      user_input_q   <= user_input_d;
      pending_q      <= pending_d;
      // Low on the first draw_char cycle so a stale done pulse is not taken.
      char_armed_q   <= (state_q == StDrawChar);
      init_q         <= (state_d == StInit);
      idle_q         <= (state_d == StIdle);
      reg_action_q   <= (state_d == StReg);
      apply_action_q <= (state_d == StApply);
      draw_map_q     <= (state_d == StDrawMap);
      draw_char_q    <= (state_d == StDrawChar);
    end
  end

  assign bus.init         = init_q;
  assign bus.idle         = idle_q;
  assign bus.reg_action   = reg_action_q;
  assign bus.apply_action = apply_action_q;
  assign bus.draw_map     = draw_map_q;
  assign bus.draw_char    = draw_char_q;
  assign bus.user_input   = user_input_q;

endmodule

// File: tb/tb_link_game_ctrl.sv
// Directed bench for link_game_ctrl: a cycle table for the main loop plus hand sequences
// for attack, collision timing, mid-operation reset, long char draw and pending ticks.
module tb_link_game_ctrl;

  logic clock = 1'b0;
  logic reset;
  logic reset2;

  always #5 clock = ~clock;

  link_game_ctrl_if bus ();
  link_game_ctrl_if bus2 ();

  link_game_ctrl #(.FRAMES_PER_MOVE(2), .CHECK_CYCLES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  link_game_ctrl #(.FRAMES_PER_MOVE(1), .CHECK_CYCLES(1)) dut2 (
    .clock (clock),
    .reset (reset2),
    .bus   (bus2)
  );

  // Strobe order: {init, draw_map, draw_char, idle, reg_action, apply_action}
  typedef struct {
    logic       rst;
    logic [4:0] keys;  // {attack, up, down, left, right}
    logic       tick;
    logic       md;
    logic       cd;
    logic [1:0] coll;
    logic [5:0] exp_st;
    logic [2:0] exp_ui;
  } vec_t;

  localparam int NumVec = 25;
  vec_t vecs[NumVec];

  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic rst, input logic [4:0] keys, input logic tick,
                              input logic md, input logic cd, input logic [1:0] coll,
                              input logic [5:0] exp_st, input logic [2:0] exp_ui);
    vec_t v;
    v.rst = rst; v.keys = keys; v.tick = tick; v.md = md; v.cd = cd; v.coll = coll;
    v.exp_st = exp_st; v.exp_ui = exp_ui;
    return v;
  endfunction

  function automatic logic [5:0] st1();
    return {bus.init, bus.draw_map, bus.draw_char, bus.idle, bus.reg_action, bus.apply_action};
  endfunction

  function automatic logic [5:0] st2();
    return {bus2.init, bus2.draw_map, bus2.draw_char, bus2.idle, bus2.reg_action,
            bus2.apply_action};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic zero_inputs();
    bus.key_attack = 0; bus.key_up = 0; bus.key_down = 0; bus.key_left = 0; bus.key_right = 0;
    bus.frame_tick = 0; bus.map_done = 0; bus.char_done = 0; bus.collision = 2'b00;
    bus2.key_attack = 0; bus2.key_up = 0; bus2.key_down = 0; bus2.key_left = 0;
    bus2.key_right = 0; bus2.frame_tick = 0; bus2.map_done = 0; bus2.char_done = 0;
    bus2.collision = 2'b00;
  endtask

  // From draw_map: map done, char done (first cycle ignored), two frame ticks -> reg phase.
  task automatic run_to_reg(input string name);
    bus.map_done = 1; step(); bus.map_done = 0;
    bus.char_done = 1; step(); step(); bus.char_done = 0;
    bus.frame_tick = 1; step(); step(); bus.frame_tick = 0;
    check(name, {2'b00, st1()}, 8'b00_000010);
  endtask

  initial begin
    bit hold_ok;

    vecs[0]  = mk(1, 5'b00000, 0, 0, 0, 2'b00, 6'b000000, 3'd0);
    vecs[1]  = mk(0, 5'b00000, 0, 0, 0, 2'b00, 6'b100000, 3'd0);
    vecs[2]  = mk(0, 5'b00000, 0, 0, 0, 2'b00, 6'b010000, 3'd0);
    vecs[3]  = mk(0, 5'b00000, 0, 0, 0, 2'b00, 6'b010000, 3'd0);
    vecs[4]  = mk(0, 5'b00000, 0, 0, 0, 2'b00, 6'b010000, 3'd0);
    vecs[5]  = mk(0, 5'b00000, 0, 1, 0, 2'b00, 6'b001000, 3'd0);
    vecs[6]  = mk(0, 5'b00000, 0, 0, 1, 2'b00, 6'b001000, 3'd0);
    vecs[7]  = mk(0, 5'b00000, 0, 0, 1, 2'b00, 6'b000100, 3'd0);
    vecs[8]  = mk(0, 5'b00000, 0, 0, 0, 2'b00, 6'b000100, 3'd0);
    vecs[9]  = mk(0, 5'b00000, 1, 0, 0, 2'b00, 6'b000100, 3'd0);
    vecs[10] = mk(0, 5'b00000, 0, 0, 0, 2'b00, 6'b000100, 3'd0);
    vecs[11] = mk(0, 5'b00000, 1, 0, 0, 2'b00, 6'b000010, 3'd0);
    vecs[12] = mk(0, 5'b01001, 0, 0, 0, 2'b00, 6'b000000, 3'd2);
    vecs[13] = mk(0, 5'b00000, 0, 0, 0, 2'b00, 6'b000000, 3'd2);
    vecs[14] = mk(0, 5'b00000, 0, 0, 0, 2'b00, 6'b000001, 3'd2);
    vecs[15] = mk(0, 5'b10000, 0, 0, 0, 2'b00, 6'b010000, 3'd2);
    vecs[16] = mk(0, 5'b00000, 1, 1, 0, 2'b00, 6'b001000, 3'd2);
    vecs[17] = mk(0, 5'b00000, 0, 0, 0, 2'b00, 6'b001000, 3'd2);
    vecs[18] = mk(0, 5'b00000, 0, 0, 1, 2'b00, 6'b000100, 3'd2);
    vecs[19] = mk(0, 5'b00000, 0, 0, 0, 2'b00, 6'b000100, 3'd2);
    vecs[20] = mk(0, 5'b00000, 1, 0, 0, 2'b00, 6'b000010, 3'd2);
    vecs[21] = mk(0, 5'b00010, 0, 0, 0, 2'b00, 6'b000000, 3'd4);
    vecs[22] = mk(0, 5'b00000, 0, 0, 0, 2'b11, 6'b000000, 3'd4);
    vecs[23] = mk(0, 5'b00000, 0, 0, 0, 2'b01, 6'b000001, 3'd0);
    vecs[24] = mk(0, 5'b00000, 0, 0, 0, 2'b00, 6'b010000, 3'd0);

    zero_inputs();
    reset  = 1;
    reset2 = 1;

    for (int i = 0; i < NumVec; i++) begin
      reset          = vecs[i].rst;
      bus.key_attack = vecs[i].keys[4];
      bus.key_up     = vecs[i].keys[3];
      bus.key_down   = vecs[i].keys[2];
      bus.key_left   = vecs[i].keys[1];
      bus.key_right  = vecs[i].keys[0];
      bus.frame_tick = vecs[i].tick;
      bus.map_done   = vecs[i].md;
      bus.char_done  = vecs[i].cd;
      bus.collision  = vecs[i].coll;
      step();
      check($sformatf("vec%0d_strobes", i), {2'b00, st1()}, {2'b00, vecs[i].exp_st});
      check($sformatf("vec%0d_user_input", i), {5'b0, bus.user_input}, {5'b0, vecs[i].exp_ui});
    end
    zero_inputs();

    // Attack is never blocked, even with collision on every check cycle.
    run_to_reg("attack_reach_reg");
    bus.key_attack = 1; bus.key_up = 1; bus.collision = 2'b11;
    step();
    bus.key_attack = 0; bus.key_up = 0;
    check("attack_latch", {5'b0, bus.user_input}, 8'd1);
    step(); step();
    check("attack_apply", {2'b00, st1()}, 8'b00_000001);
    check("attack_unblocked", {5'b0, bus.user_input}, 8'd1);
    bus.collision = 2'b00;
    step();
    check("apply_to_map", {2'b00, st1()}, 8'b00_010000);

    // Collision only on a non-final check cycle must not block the move.
    run_to_reg("down_reach_reg");
    bus.key_down = 1; step(); bus.key_down = 0;
    bus.collision = 2'b10; step(); bus.collision = 2'b00;
    step();
    check("down_apply", {2'b00, st1()}, 8'b00_000001);
    check("down_early_coll", {5'b0, bus.user_input}, 8'd3);
    step();

    // Reset in the check phase, then a long character draw.
    run_to_reg("right_reach_reg");
    bus.key_right = 1; step(); bus.key_right = 0;
    check("right_in_check", {5'b0, bus.user_input}, 8'd5);
    reset = 1; step(); reset = 0;
    check("reset_strobes", {2'b00, st1()}, 8'b00_000000);
    check("reset_user_input", {5'b0, bus.user_input}, 8'd0);
    step();
    check("reset_init", {2'b00, st1()}, 8'b00_100000);
    step();
    check("reset_map", {2'b00, st1()}, 8'b00_010000);
    bus.map_done = 1; step(); bus.map_done = 0;
    hold_ok = 1;
    repeat (256) begin
      step();
      if (st1() !== 6'b001000) hold_ok = 0;
    end
    check("char_hold_256", {7'b0, hold_ok}, 8'd1);
    bus.char_done = 1; step(); bus.char_done = 0;
    check("char_to_idle", {2'b00, st1()}, 8'b00_000100);
    check("idle_user_input", {5'b0, bus.user_input}, 8'd0);

    // Second instance: a tick during map draw carries into idle, with FRAMES_PER_MOVE=1.
    reset2 = 0;
    step();
    check("d2_init", {2'b00, st2()}, 8'b00_100000);
    step();
    check("d2_map", {2'b00, st2()}, 8'b00_010000);
    bus2.frame_tick = 1; step(); bus2.frame_tick = 0;
    check("d2_map_tick", {2'b00, st2()}, 8'b00_010000);
    bus2.map_done = 1; step(); bus2.map_done = 0;
    check("d2_char", {2'b00, st2()}, 8'b00_001000);
    bus2.char_done = 1; step(); step(); bus2.char_done = 0;
    check("d2_idle_entry", {2'b00, st2()}, 8'b00_000100);
    step();
    check("d2_reg_pending", {2'b00, st2()}, 8'b00_000010);
    bus2.key_right = 1; step(); bus2.key_right = 0;
    check("d2_check", {2'b00, st2()}, 8'b00_000000);
    check("d2_right", {5'b0, bus2.user_input}, 8'd5);
    step();
    check("d2_apply", {2'b00, st2()}, 8'b00_000001);
    check("d2_apply_ui", {5'b0, bus2.user_input}, 8'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
